// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: processes DIGIT bits of two WIDTH-bit operands
// per clock, ripple carry held in a register between digits, valid/ready on both sides.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               carry_out_q, carry_out_d;
   logic               overflow_q, overflow_d;
   logic [DIGIT:0]     digit_res;
   logic               last_digit;

   // One DIGIT+1 bit add per cycle; the top bit is the carry into the next digit.
   assign digit_res  = {1'b0, a_q[cnt_q*DIGIT +: DIGIT]}
                     + {1'b0, b_q[cnt_q*DIGIT +: DIGIT]}
                     + {{DIGIT{1'b0}}, carry_q};
   assign last_digit = (cnt_q == CNT_W'(N - 1));

   // NOTE: every _d gets its _q value first, so no path through this block leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b ^ {WIDTH{sub}};
               carry_d = sub | carry_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[cnt_q*DIGIT +: DIGIT] = digit_res[DIGIT-1:0];
            carry_d = digit_res[DIGIT];
            if (last_digit) begin
               carry_out_d = digit_res[DIGIT];
               // Signed overflow: operands agree in sign but the result does not.
               overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                             (digit_res[DIGIT-1] != a_q[WIDTH-1]);
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update
   // together from values sampled before the edge. The operand registers are reset
   // as well, so a reset mid-operation leaves no stale data behind.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule
